// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with valid/ready load and tick-driven shifting
//
// Purpose:
//   Accepts a WIDTH-bit word through a valid/ready handshake and emits it
//   one bit per shift_en tick. ser_valid/busy mark frame bits and done
//   pulses for one cycle after the last bit has been consumed.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1 = emit bit WIDTH-1 first, 0 = emit bit 0 first
//
// Ports:
//   clk         system clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   load_valid  source presents a word on load_data
//   load_ready  block can accept a word this cycle
//   load_data   parallel word to transmit
//   shift_en    bit-advance tick, sampled on posedge clk
//   ser_out     current serial bit
//   ser_valid   ser_out holds a frame bit
//   busy        frame in progress (same as ser_valid)
//   done        one-cycle pulse after the last bit is consumed

module piso_serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] BCNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] BCNT_ONE  = CW'(1);
    localparam logic [CW-1:0] BCNT_ZERO = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    bcnt_q,  bcnt_d;
    logic             done_q,  done_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sreg_d  = load_data;
                    bcnt_d  = BCNT_FULL;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // bcnt is never zero in SHIFT; the guard keeps the counter from wrapping.
                if (shift_en && (bcnt_q != BCNT_ZERO)) begin
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end
                    bcnt_d = bcnt_q - BCNT_ONE;
                    if (bcnt_q == BCNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        load_ready = (state_q == IDLE);
        ser_valid  = (state_q == SHIFT);
        busy       = ser_valid;
        ser_out    = 1'b0;
        if (state_q == SHIFT) begin
            ser_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
        done = done_q;
    end

endmodule
